// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate, load and clear with fill tracking.
// Optional registered parity output when UNIV_SHIFT_REG_PARITY_EN is defined.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             x,
    input  logic [WIDTH-1:0] load_data,
`ifdef UNIV_SHIFT_REG_PARITY_EN
    output logic             parity,
`endif
    output logic [WIDTH-1:0] shift_value,
    output logic             sout,
    output logic [CW-1:0]    fill_cnt,
    output logic             full
);

    typedef enum logic [2:0] {
        M_HOLD = 3'd0,
        M_SHL  = 3'd1,
        M_SHR  = 3'd2,
        M_ROL  = 3'd3,
        M_ROR  = 3'd4,
        M_LOAD = 3'd5,
        M_CLR  = 3'd6,
        M_RSVD = 3'd7
    } mode_e;

    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

    mode_e            op;
    logic [WIDTH-1:0] val_n;
    logic             sout_n;
    logic [CW-1:0]    fill_n;
    logic [CW-1:0]    fill_inc;

    assign op = mode_e'(mode);

    // Saturate so shifting a full register never wraps the count.
    assign fill_inc = (fill_cnt == FULL_CNT) ? FULL_CNT : fill_cnt + CW'(1);

    always_comb begin
        val_n  = shift_value;
        sout_n = sout;
        fill_n = fill_cnt;
        if (en) begin
            unique case (op)
                M_SHL: begin
                    val_n  = {shift_value[WIDTH-2:0], x};
                    sout_n = shift_value[WIDTH-1];
                    fill_n = fill_inc;
                end
                M_SHR: begin
                    val_n  = {x, shift_value[WIDTH-1:1]};
                    sout_n = shift_value[0];
                    fill_n = fill_inc;
                end
                M_ROL: begin
                    val_n  = {shift_value[WIDTH-2:0], shift_value[WIDTH-1]};
                    sout_n = shift_value[WIDTH-1];
                end
                M_ROR: begin
                    val_n  = {shift_value[0], shift_value[WIDTH-1:1]};
                    sout_n = shift_value[0];
                end
                M_LOAD: begin
                    val_n  = load_data;
                    fill_n = FULL_CNT;
                end
                M_CLR: begin
                    val_n  = '0;
                    fill_n = '0;
                end
                M_HOLD, M_RSVD: begin
                end
                default: begin
                end
            endcase
        end
    end

    // full is derived from the next count so it lands on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_value <= '0;
            sout        <= 1'b0;
            fill_cnt    <= '0;
            full        <= 1'b0;
        end else begin
            shift_value <= val_n;
            sout        <= sout_n;
            fill_cnt    <= fill_n;
            full        <= (fill_n == FULL_CNT);
        end
    end

`ifdef UNIV_SHIFT_REG_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            parity <= 1'b0;
        end else begin
            parity <= ^val_n;
        end
    end
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: arithmetic reference model checked every cycle
// plus directed literal checks.
module tb_univ_shift_reg;

    localparam int W = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [2:0]    mode;
    logic          x;
    logic [W-1:0]  load_data;
    logic [W-1:0]  shift_value;
    logic          sout;
    logic [CW-1:0] fill_cnt;
    logic          full;
`ifdef UNIV_SHIFT_REG_PARITY_EN
    logic          parity;
`endif

    int passed = 0;
    int total = 0;

    int  m_val = 0;
    int  m_sout = 0;
    int  m_fill = 0;
    bit  armed = 1'b0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .mode(mode),
        .x(x),
        .load_data(load_data),
`ifdef UNIV_SHIFT_REG_PARITY_EN
        .parity(parity),
`endif
        .shift_value(shift_value),
        .sout(sout),
        .fill_cnt(fill_cnt),
        .full(full)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the register value.
    always @(posedge clk) begin
        if (!reset) begin
            m_val = 0;
            m_sout = 0;
            m_fill = 0;
            armed = 1'b1;
        end else if (en) begin
            case (int'(mode))
                1: begin
                    m_sout = m_val / 128;
                    m_val = (m_val * 2 + int'(x)) % 256;
                    m_fill = (m_fill < W) ? m_fill + 1 : W;
                end
                2: begin
                    m_sout = m_val % 2;
                    m_val = m_val / 2 + int'(x) * 128;
                    m_fill = (m_fill < W) ? m_fill + 1 : W;
                end
                3: begin
                    m_sout = m_val / 128;
                    m_val = (m_val * 2 + m_val / 128) % 256;
                end
                4: begin
                    m_sout = m_val % 2;
                    m_val = m_val / 2 + (m_val % 2) * 128;
                end
                5: begin
                    m_val = int'(load_data);
                    m_fill = W;
                end
                6: begin
                    m_val = 0;
                    m_fill = 0;
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input longint act,
                       input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("model_val", longint'(shift_value), longint'(m_val));
            chk("model_sout", longint'(sout), longint'(m_sout));
            chk("model_fill", longint'(fill_cnt), longint'(m_fill));
            chk("model_full", longint'(full), longint'(m_fill == W));
`ifdef UNIV_SHIFT_REG_PARITY_EN
            chk("model_par", longint'(parity),
                longint'($countones(m_val[7:0]) % 2));
`endif
        end
    end

    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic xi, input logic [W-1:0] ld);
        @(negedge clk);
        reset = r;
        en = e;
        mode = m;
        x = xi;
        load_data = ld;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bits;

    initial begin
        reset = 1'b1;
        en = 1'b0;
        mode = 3'd0;
        x = 1'b0;
        load_data = '0;

        step(1'b0, 1'b1, 3'd5, 1'b0, 8'hFF);
        step(1'b0, 1'b1, 3'd5, 1'b0, 8'hFF);
        chk("rst_val", shift_value, 8'h00);
        chk("rst_fill", fill_cnt, 0);
        chk("rst_full", full, 0);
        chk("rst_sout", sout, 0);

        bits = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 3'd1, bits[7-i], 8'h00);
            chk("shl_fill", fill_cnt, i + 1);
            chk("shl_full", full, (i == 7) ? 1 : 0);
        end
        chk("shl_val", shift_value, 8'hB2);

        step(1'b1, 1'b1, 3'd5, 1'b0, 8'h81);
        step(1'b1, 1'b1, 3'd4, 1'b0, 8'h00);
        chk("ror_val", shift_value, 8'hC0);
        chk("ror_sout", sout, 1);
        chk("ror_fill", fill_cnt, 8);
        step(1'b1, 1'b1, 3'd3, 1'b0, 8'h00);
        step(1'b1, 1'b1, 3'd3, 1'b0, 8'h00);
        chk("rol_val", shift_value, 8'h03);
        chk("rol_sout", sout, 1);

        step(1'b1, 1'b1, 3'd5, 1'b0, 8'hA5);
        bits = 8'b0000_0101;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 3'd2, 1'b0, 8'h00);
            chk("shr_sout", sout, bits[2-i]);
            chk("shr_fill", fill_cnt, 8);
        end
        chk("shr_val", shift_value, 8'h14);

        step(1'b1, 1'b1, 3'd7, 1'b1, 8'h00);
        chk("rsvd_val", shift_value, 8'h14);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'd1, 1'b1, 8'h00);
        step(1'b0, 1'b1, 3'd1, 1'b1, 8'h00);
        chk("mid_rst_fill", fill_cnt, 0);
        step(1'b1, 1'b1, 3'd1, 1'b1, 8'h00);
        chk("post_rst_fill", fill_cnt, 1);
        chk("post_rst_val", shift_value, 8'h01);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3'd1, 1'b1, 8'hFF);
        chk("en0_val", shift_value, 8'h01);
        chk("en0_fill", fill_cnt, 1);
        chk("en0_full", full, 0);

        step(1'b1, 1'b1, 3'd5, 1'b0, 8'h07);
`ifdef UNIV_SHIFT_REG_PARITY_EN
        chk("par_load", parity, 1);
`endif
        chk("load_full", full, 1);
        step(1'b1, 1'b1, 3'd6, 1'b0, 8'h00);
`ifdef UNIV_SHIFT_REG_PARITY_EN
        chk("par_clr", parity, 0);
`endif
        chk("clr_val", shift_value, 8'h00);
        chk("clr_fill", fill_cnt, 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set register width; legal range 2..64.
REQ-002 Parameter CW, default $clog2(WIDTH+1), SHALL set the fill_cnt width (derived, not overridden).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset.
REQ-005 en  input  1  SHALL qualify mode; en=0 SHALL hold all state.
REQ-006 mode  input  3  SHALL select the operation per REQ-010.
REQ-007 x  input  1  SHALL be the serial data-in bit.
REQ-008 load_data  input  WIDTH  SHALL be the parallel load value.
REQ-009 Outputs: shift_value  output  WIDTH  register contents; sout  output  1  last bit shifted or rotated out; fill_cnt  output  CW  valid serial bits held; full  output  1  fill_cnt==WIDTH.

Function
REQ-010 When en=1, mode SHALL act at the clock edge: 0 hold; 1 shift left, x into bit 0; 2 shift right, x into bit WIDTH-1; 3 rotate left; 4 rotate right; 5 parallel load of load_data; 6 clear to zero; 7 reserved, same as hold.
REQ-011 All outputs SHALL be registered; each result SHALL appear one cycle after the sampling edge.
REQ-012 sout SHALL update only on modes 1-4: bit WIDTH-1 for modes 1/3, bit 0 for modes 2/4. Its value is the pre-shift bit. It SHALL hold otherwise.
REQ-013 fill_cnt SHALL increment on modes 1/2 and saturate at WIDTH. It SHALL hold on modes 0/3/4/7 and on en=0. Mode 5 SHALL set it to WIDTH. Mode 6 SHALL set it to 0.
REQ-014 full SHALL be a registered flag equal to (fill_cnt==WIDTH) after the same edge, with no extra cycle of lag.
REQ-015 A shift at fill_cnt==WIDTH SHALL still shift data and SHALL keep fill_cnt at WIDTH, with no wrap-around.
REQ-016 Mode and load_data SHALL be sampled only at the clock edge; mid-cycle changes SHALL have no effect.

Reset
REQ-017 When reset=0 at a rising edge, shift_value, sout and fill_cnt SHALL become 0 and full SHALL become 0, regardless of en and mode.
REQ-018 Reset SHALL take priority over every mode, including a load in the same cycle.
REQ-019 Reset asserted mid-operation SHALL discard the partial fill. The first edge with reset=1 SHALL execute the mode then present.

Configuration
REQ-020 When macro UNIV_SHIFT_REG_PARITY_EN is defined, the block SHALL add an output parity (1 bit, registered) equal to the XOR of the next shift_value. It SHALL update in the same cycle as shift_value and reset to 0.
REQ-021 When UNIV_SHIFT_REG_PARITY_EN is undefined, the parity port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=8)
REQ-022 Apply reset=0 for 2 cycles with en=1, mode=5, load_data=8'hFF -> shift_value=8'h00, fill_cnt=0, full=0, sout=0.
REQ-023 Release reset, then shift left 8 cycles with x=1,0,1,1,0,0,1,0 -> shift_value=8'hB2. fill_cnt goes 1..8, and full asserts on the 8th edge.
REQ-024 Load 8'h81, then rotate right once -> shift_value=8'hC0, sout=1, fill_cnt=8. Then rotate left twice -> shift_value=8'h03, sout=1.
REQ-025 Load 8'hA5, then shift right 3 cycles with x=0 -> shift_value=8'h14, sout sequence 1,0,1, fill_cnt stays 8.
REQ-026 Shift 5 bits, assert reset for 1 cycle, then shift 1 bit with x=1 -> fill_cnt=1, shift_value=8'h01. Also en=0 with mode=1 for 4 cycles -> no state change.
REQ-027 With UNIV_SHIFT_REG_PARITY_EN defined, load 8'h07 -> parity=1, then clear -> parity=0. The build without the macro SHALL pass REQ-022..026 unchanged.
